// File: rtl/w_fac_pkg.sv
// Shared types for the twiddle-factor RAM loader and read side.
// Word layout {im, re} matches the twiddle RAM.
package w_fac_pkg;

    localparam int W_HALF = 32;
    localparam int W_WORD = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_RE,
        LOAD_IM,
        FINISH
    } state_t;

    typedef struct packed {
        logic [W_HALF-1:0] im;
        logic [W_HALF-1:0] re;
    } cplx_t;

endpackage

// File: rtl/w_fac_ram_loader_if.sv
// Half-word input stream plus twiddle RAM write port.
// slave = loader side, master = host/RAM side.
interface w_fac_ram_loader_if #(
    parameter int AW = 12
);
    import w_fac_pkg::*;

    logic              s_valid;
    logic [W_HALF-1:0] s_data;
    logic              s_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W_WORD-1:0] wr_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/w_fac_csum.sv
// Running XOR of every word written during one load.
// Only instantiated with W_FAC_CHECKSUM_EN.
module w_fac_csum
    import w_fac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [W_WORD-1:0] data,
    output logic [W_WORD-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum ^ data;
        end
    end

endmodule

// File: rtl/w_fac_ram_loader.sv
// Packs a re/im half-word stream into N twiddle RAM writes.
// Optional checksum: define W_FAC_CHECKSUM_EN.
module w_fac_ram_loader
    import w_fac_pkg::*;
#(
    parameter  int N  = 4096,
    localparam int AW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    w_fac_ram_loader_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic [W_WORD-1:0]  checksum
);

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     cnt_q;
    logic [W_HALF-1:0] re_q;
    logic              wr_en_q;
    logic [AW-1:0]     wr_addr_q;
    cplx_t             wr_data_q;
    logic              done_q;
    logic              s_ready_c;
    logic              busy_c;
    logic              xfer;
    logic              start_go;
    logic              wr_go;
    logic              last;
    cplx_t             word;

    // abort wins over a same-cycle handshake
    assign xfer     = bus.s_valid && s_ready_c && !abort;
    assign start_go = (state_q == IDLE) && start;
    assign wr_go    = (state_q == LOAD_IM) && xfer;
    assign last     = (cnt_q == AW'(N - 1));
    assign word     = '{im: bus.s_data, re: re_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_RE;
            end
            LOAD_RE: begin
                if (abort)     state_d = IDLE;
                else if (xfer) state_d = LOAD_IM;
            end
            LOAD_IM: begin
                if (abort)     state_d = IDLE;
                else if (xfer) state_d = last ? FINISH : LOAD_RE;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready_c = 1'b0;
        busy_c    = 1'b0;
        unique case (state_q)
            IDLE:    ;
            LOAD_RE: begin s_ready_c = 1'b1; busy_c = 1'b1; end
            LOAD_IM: begin s_ready_c = 1'b1; busy_c = 1'b1; end
            FINISH:  busy_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            re_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= wr_go;
            done_q  <= (state_q == FINISH) && !abort;
            if (start_go) cnt_q <= '0;
            if (abort && state_q != IDLE) re_q <= '0;
            else if (state_q == LOAD_RE && xfer) re_q <= bus.s_data;
            if (wr_go) begin
                wr_addr_q <= cnt_q;
                wr_data_q <= word;
                cnt_q     <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_c;
    assign done        = done_q;

`ifdef W_FAC_CHECKSUM_EN
    w_fac_csum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_go),
        .en    (wr_go),
        .data  (word),
        .sum   (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/w_fac_ram_loader.md
Name: w_fac_ram_loader

Overview:
- Write-side counterpart of the twiddle-factor RAM read port: fills the N-entry twiddle memory at run time instead of relying on a preloaded file.
- Accepts a ready/valid stream of 32-bit halves (real first, then imaginary) and packs each pair into one 64-bit word, {32-bit im, 32-bit re}.
- Issues one write per word at sequential addresses 0..N-1, then pulses done.
- Sits between the host/config interface and the twiddle RAM's write port.

Parameters:
- N, 4096, number of twiddle entries; power of two, >= 2.
- AW, $clog2(N) (localparam), address width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a load; sampled only in IDLE.
- abort  in  1  synchronous cancel of a load in progress.
- s_valid  in  1  stream half-word valid.
- s_data  in  32  stream half-word; real part, then imaginary part, alternating.
- s_ready  out  1  loader can accept s_data.
- wr_en  out  1  RAM write strobe, one cycle per word.
- wr_addr  out  AW  RAM write address.
- wr_data  out  64  {im[31:0], re[31:0]}.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse after the final write.
- checksum  out  64  see Optional Feature.

Behaviour:
- Reset values: every output 0; internal state IDLE; word counter 0; re holding register 0.
- States: IDLE, LOAD_RE, LOAD_IM, FINISH.
- s_ready is combinational from state: 1 in LOAD_RE and LOAD_IM, 0 otherwise.
- A transfer occurs when s_valid && s_ready.
- IDLE:
  - start=1 at edge k gives state LOAD_RE, busy=1, counter=0, checksum cleared, from k+1.
  - s_ready is therefore first high in cycle k+1.
- LOAD_RE: on transfer, latch s_data into re_hold; go to LOAD_IM. No transfer means stay.
- LOAD_IM: on transfer at edge T:
  - wr_en=1, wr_addr=counter, wr_data={s_data, re_hold} in cycle T+1 (registered).
  - Counter increments.
  - If counter was N-1, go to FINISH; otherwise go to LOAD_RE.
- wr_en is high for exactly one cycle per completed pair. wr_addr and wr_data hold their last values when wr_en=0.
- FINISH (entered at T+1, same cycle as the final wr_en): at the next edge, done=1 for one cycle, busy=0, state IDLE. Net result: done is high in cycle T+2.
- Peak throughput: one half-word per cycle, so one write every 2 cycles. s_valid gaps stall without loss.
- start while busy: ignored.
- start in the same cycle that done is high: accepted (state is IDLE).
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE, busy=0, s_ready=0, no done pulse.
  - A pending re_hold is discarded. Words already written stay written.
  - abort has priority over a simultaneous transfer; that half-word is not consumed, because s_ready drops only after the edge. The upstream side must treat a transfer in that cycle as lost.
- abort in IDLE: no effect.
- Reset mid-load: immediate return to reset values; the partial load is abandoned.
- Counter wrap: the counter never exceeds N-1. It is cleared on start.

Optional Feature:
- Macro: W_FAC_CHECKSUM_EN.
- With the macro defined:
  - checksum = running 64-bit XOR of every wr_data written in the current load.
  - Updated in the same cycle wr_en is high.
  - Cleared on start and on reset; held after done or abort.
- Without the macro: checksum is tied to 0 and no accumulator register is built.

Decomposition:
- Package w_fac_pkg holds:
  - W_HALF=32 and W_WORD=64;
  - a state typedef enum {IDLE, LOAD_RE, LOAD_IM, FINISH};
  - a packed cplx_t {im, re} struct matching the RAM word layout, shared with the read-side RAM.
- Single module otherwise. The checksum accumulator is a natural sub-module, w_fac_csum, instantiated only under W_FAC_CHECKSUM_EN.

Test Plan (N=8):
- Basic load: start, then 16 back-to-back halves re_i=0x1000+i, im_i=0x2000+i → 8 wr_en pulses, every 2nd cycle, addr 0..7, wr_data[i]=0x00002000+i_00001000+i; done is high exactly 2 cycles after the last transfer; busy falls together with done.
- Stalled stream: s_valid toggling with a random 30% duty → identical writes and addresses as the basic load; no extra wr_en pulses; s_ready never high in IDLE or FINISH.
- Abort: abort after 5 halves (2 words plus 1 re) → writes to addr 0,1 only; busy=0 the next cycle; no done. A fresh start then rewrites from addr 0.
- Start while busy: second start pulse at word 3 → ignored; load completes with 8 writes and a single done.
- Reset mid-load: rst_n low at word 4 → all outputs 0 asynchronously; after release, no wr_en until the next start.
- Checksum (macro on): data from the basic load → checksum equals the XOR of the 8 words, i.e. 64'h0000000000000000 for this pattern (8 consecutive indices XOR to 0); with im_i=i*3 it must match the reference-model XOR. With the macro off, checksum stays 0.
